// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// min_digits() is elaborated at compile time and by the testbench only.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // Smallest d with 10^d >= 2^width, i.e. ceil(width*log10(2)).
    function automatic int min_digits(input int width);
        longint unsigned pow2;
        longint unsigned pow10;
        int              d;
        pow2  = 64'd1 << width;
        pow10 = 64'd1;
        d     = 0;
        while (pow10 < pow2) begin
            pow10 = pow10 * 64'd10;
            d     = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries cleanly into the next decimal digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    always_comb begin
        if (digit_in >= BCD_DIGIT_W'(5)) begin
            digit_out = digit_in + BCD_DIGIT_W'(3);
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock,
// with start/busy/done handshake and optional two's-complement input.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          CLOCK_50,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          signed_mode,
    input  logic [WIDTH-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic                          neg,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               neg_q, neg_d;
    logic               neg_pend_q, neg_pend_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic [BCD_W-1:0]   bcd_acc_q, bcd_acc_d;
    logic [WIDTH-1:0]   bin_sr_q, bin_sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [BCD_W-1:0]       adj_acc;
    logic [BCD_W+WIDTH-1:0] work_next;
    logic                   in_is_neg;
    logic [WIDTH-1:0]       in_mag;
    logic                   capture;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (bcd_acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (adj_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        state_d    = state_q;
        neg_d      = neg_q;
        neg_pend_d = neg_pend_q;
        bcd_out_d  = bcd_out_q;
        bcd_acc_d  = bcd_acc_q;
        bin_sr_d   = bin_sr_q;
        cnt_d      = cnt_q;

        // The most negative input negates to 2^(WIDTH-1), which still fits unsigned.
        in_is_neg = signed_mode & bin_in[WIDTH-1];
        in_mag    = in_is_neg ? (~bin_in + WIDTH'(1)) : bin_in;
        work_next = {adj_acc, bin_sr_q} << 1;
        capture   = start && (state_q == IDLE || state_q == DONE);

        case (state_q)
            IDLE, DONE: begin
                state_d = capture ? SHIFT : IDLE;
            end
            SHIFT: begin
                bcd_acc_d = work_next[BCD_W+WIDTH-1:WIDTH];
                bin_sr_d  = work_next[WIDTH-1:0];
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = DONE;
                    bcd_out_d = work_next[BCD_W+WIDTH-1:WIDTH];
                    neg_d     = neg_pend_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            bcd_acc_d  = '0;
            bin_sr_d   = in_mag;
            cnt_d      = CNT_W'(WIDTH);
            neg_pend_d = in_is_neg;
        end

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            neg_q      <= 1'b0;
            neg_pend_q <= 1'b0;
            bcd_out_q  <= '0;
            bcd_acc_q  <= '0;
            bin_sr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            neg_q      <= neg_d;
            neg_pend_q <= neg_pend_d;
            bcd_out_q  <= bcd_out_d;
            bcd_acc_q  <= bcd_acc_d;
            bin_sr_q   <= bin_sr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign neg     = neg_q;
    assign bcd_out = bcd_out_q;

endmodule
